power_phase_sched: RTL



---
 rtl/power_phase_sched_pkg.sv | 28 ++
 rtl/power_phase_sched_heartbeat_div.sv | 22 ++
 rtl/power_phase_sched.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/power_phase_sched_pkg.sv
// Shared types and helpers for the power-characterisation phase sequencer.
package power_test_pkg;

    localparam int SIG_W   = 16;
    localparam int MAX_GRP = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARM,
        ST_RUN,
        ST_DRAIN,
        ST_CHECK,
        ST_DONE,
        ST_FAIL
    } state_t;

    // One-hot on the phase index in sequential mode, every present group in concurrent mode.
    function automatic logic [MAX_GRP-1:0] phase_mask(input logic mode, input logic [2:0] idx,
                                                      input int num_grp);
        logic [MAX_GRP-1:0] m;
        m = '0;
        for (int g = 0; g < MAX_GRP; g++)
            if (g < num_grp && (mode || idx == 3'(g)))
                m[g] = 1'b1;
        return m;
    endfunction

endpackage

// File: rtl/power_phase_sched_heartbeat_div.sv
// Free-running LED heartbeat prescaler; strobes once per 2^LED_DIV cycles.
module heartbeat_div #(
    parameter int LED_DIV = 24
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clr,
    output logic o_toggle
);

    logic [LED_DIV-1:0] r_cnt;

    always_ff @(posedge i_clk) begin
        if (i_rst || i_clr)
            r_cnt <= '0;
        else
            r_cnt <= r_cnt + 1'b1;
    end

    assign o_toggle = &r_cnt;

endmodule

// File: rtl/power_phase_sched.sv
// Runs the activity groups through timed phases and checks their returned signatures.
module power_phase_sched
    import power_test_pkg::*;
#(
    parameter int NUM_GRP       = 4,
    parameter int PHASE_CYCLES  = 1024,
    parameter int DRAIN_TIMEOUT = 64,
    parameter int LED_DIV       = 24
) (
    input  logic                     sys_clk,
    input  logic                     sys_rst,
    input  logic                     start,
    input  logic                     mode,
    output logic [NUM_GRP-1:0]       grp_start,
    output logic [NUM_GRP-1:0]       grp_en,
    input  logic [NUM_GRP-1:0]       grp_sig_valid,
    input  logic [SIG_W*NUM_GRP-1:0] grp_sig,
    input  logic [SIG_W*NUM_GRP-1:0] exp_sig,
    output logic                     busy,
    output logic [2:0]               phase_idx,
    output logic                     gpio_out_pass,
    output logic                     gpio_out_fail,
    output logic                     led
);

    localparam int CNT_MAX = (PHASE_CYCLES > DRAIN_TIMEOUT) ? PHASE_CYCLES : DRAIN_TIMEOUT;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] RUN_LAST   = CNT_W'(PHASE_CYCLES - 1);
    localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(DRAIN_TIMEOUT - 1);
    localparam logic [2:0]       IDX_LAST   = 3'(NUM_GRP - 1);

    state_t             r_state, w_state_nxt;
    logic               r_mode, w_mode_nxt;
    logic [2:0]         r_idx, w_idx_nxt;
    logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;

    logic [NUM_GRP-1:0] r_grp_start, r_grp_en, w_grp_start_nxt, w_grp_en_nxt;
    logic               r_busy, r_pass, r_fail, r_led;
    logic               w_busy_nxt, w_pass_nxt, w_fail_nxt, w_led_nxt;

    logic [NUM_GRP-1:0] w_mask_cur, w_mask_nxt;
    logic               w_all_valid, w_mismatch, w_accept, w_tick;

    assign w_mask_cur  = NUM_GRP'(phase_mask(r_mode, r_idx, NUM_GRP));
    assign w_mask_nxt  = NUM_GRP'(phase_mask(w_mode_nxt, w_idx_nxt, NUM_GRP));
    assign w_all_valid = &(grp_sig_valid | ~w_mask_cur);
    assign w_accept    = (r_state == ST_IDLE) && start;

    always_comb begin
        w_mismatch = 1'b0;
        for (int g = 0; g < NUM_GRP; g++)
            if (w_mask_cur[g] && grp_sig[g*SIG_W +: SIG_W] != exp_sig[g*SIG_W +: SIG_W])
                w_mismatch = 1'b1;
    end

    heartbeat_div #(.LED_DIV(LED_DIV)) u_hb (
        .i_clk    (sys_clk),
        .i_rst    (sys_rst),
        .i_clr    (w_accept),
        .o_toggle (w_tick)
    );

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_state <= ST_IDLE;
            r_mode  <= 1'b0;
            r_idx   <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_mode  <= w_mode_nxt;
            r_idx   <= w_idx_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_mode_nxt  = r_mode;
        w_idx_nxt   = r_idx;
        w_cnt_nxt   = r_cnt;
        unique case (r_state)
            ST_IDLE: if (start) begin
                w_state_nxt = ST_ARM;
                w_mode_nxt  = mode;
                w_idx_nxt   = '0;
            end
            ST_ARM: begin
                w_state_nxt = ST_RUN;
                w_cnt_nxt   = '0;
            end
            ST_RUN: if (r_cnt == RUN_LAST) begin
                w_state_nxt = ST_DRAIN;
                w_cnt_nxt   = '0;
            end else begin
                w_cnt_nxt = r_cnt + 1'b1;
            end
            // Late signatures win a tie with the timeout on the last drain cycle.
            ST_DRAIN: if (w_all_valid)
                w_state_nxt = ST_CHECK;
            else if (r_cnt == DRAIN_LAST)
                w_state_nxt = ST_FAIL;
            else
                w_cnt_nxt = r_cnt + 1'b1;
            ST_CHECK: if (w_mismatch)
                w_state_nxt = ST_FAIL;
            else if (r_mode || r_idx == IDX_LAST)
                w_state_nxt = ST_DONE;
            else begin
                w_state_nxt = ST_ARM;
                w_idx_nxt   = r_idx + 1'b1;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Outputs are decoded from the upcoming state so every port comes straight off a flop.
    always_comb begin
        w_grp_start_nxt = (w_state_nxt == ST_ARM) ? w_mask_nxt : '0;
        w_grp_en_nxt    = (w_state_nxt == ST_RUN) ? w_mask_nxt : '0;
        w_busy_nxt      = w_state_nxt inside {ST_ARM, ST_RUN, ST_DRAIN, ST_CHECK};
        w_pass_nxt      = r_pass;
        w_fail_nxt      = r_fail;
        w_led_nxt       = r_led;
        if (w_accept) begin
            w_pass_nxt = 1'b0;
            w_fail_nxt = 1'b0;
            w_led_nxt  = 1'b0;
        end else if (w_state_nxt == ST_DONE) begin
            w_pass_nxt = 1'b1;
            w_led_nxt  = 1'b1;
        end else if (w_state_nxt == ST_FAIL) begin
            w_fail_nxt = 1'b1;
            w_led_nxt  = 1'b0;
        end else if (w_busy_nxt && w_tick) begin
            w_led_nxt = ~r_led;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_grp_start <= '0;
            r_grp_en    <= '0;
            r_busy      <= 1'b0;
            r_pass      <= 1'b0;
            r_fail      <= 1'b0;
            r_led       <= 1'b0;
        end else begin
            r_grp_start <= w_grp_start_nxt;
            r_grp_en    <= w_grp_en_nxt;
            r_busy      <= w_busy_nxt;
            r_pass      <= w_pass_nxt;
            r_fail      <= w_fail_nxt;
            r_led       <= w_led_nxt;
        end
    end

    assign grp_start     = r_grp_start;
    assign grp_en        = r_grp_en;
    assign busy          = r_busy;
    assign phase_idx     = r_idx;
    assign gpio_out_pass = r_pass;
    assign gpio_out_fail = r_fail;
    assign led           = r_led;

endmodule
